// File: rtl/laser_top.sv
// laser_top: two-circle coverage optimiser.
// Loads 40 points from X/Y, then searches a 16x16 grid for two circle
// centers (radius 4) that together cover as many points as possible.
// The search alternates a full raster scan for circle 1 (circle 2 fixed)
// and a full raster scan for circle 2 (circle 1 fixed), stopping when a
// round brings no improvement or after eight rounds. The result appears on
// C1X/C1Y/C2X/C2Y with a one-cycle DONE pulse.
//
// Handshake: there is no backpressure. Each rising edge in READ captures
// X/Y as the next point; the result is valid only while DONE is high and
// is then held until the next result replaces it.

module laser_top (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    output logic [3:0] C1X,
    output logic [3:0] C1Y,
    output logic [3:0] C2X,
    output logic [3:0] C2Y,
    output logic       DONE
);

    localparam int          NUM_PTS    = 40;
    localparam logic [5:0]  LAST_PT    = 6'd39;
    localparam logic [2:0]  LAST_ROUND = 3'd7;
    localparam logic [8:0]  RADIUS_SQ  = 9'd16;

    typedef enum logic [1:0] {
        S_READ   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Point storage and load counter
    logic [5:0] cnt_q;
    logic [3:0] px_q [NUM_PTS];
    logic [3:0] py_q [NUM_PTS];

    // Search registers
    logic       phase_q;        // 0: scanning circle 1, 1: scanning circle 2
    logic [7:0] cand_q;         // raster index, y in [7:4], x in [3:0]
    logic       best_vld_q;     // clear means "best count is -1"
    logic [5:0] best_cnt_q;
    logic [3:0] best_x_q, best_y_q;
    logic [3:0] w1x_q, w1y_q;   // working center of circle 1
    logic [3:0] w2x_q, w2y_q;   // working center of circle 2
    logic [2:0] round_q;        // completed rounds
    logic [5:0] prev_cnt_q;     // union count reached by the previous round

    // Result registers
    logic [3:0] c1x_q, c1y_q, c2x_q, c2y_q;

    // Candidate evaluation signals
    logic [3:0]  cand_x, cand_y;
    logic [3:0]  fix_x, fix_y;
    logic [39:0] hit_cand, hit_fix;
    logic [5:0]  cand_cnt;
    logic        take_cand;
    logic [5:0]  win_cnt;
    logic [3:0]  win_x, win_y;
    logic        scan_last;
    logic        search_end;

    // Squared-distance test for one center/point pair. Differences are
    // taken as signed 5-bit values; the magnitudes are squared unsigned.
    function automatic logic covers(input logic [3:0] cx, input logic [3:0] cy,
                                    input logic [3:0] qx, input logic [3:0] qy);
        logic signed [4:0] dx;
        logic signed [4:0] dy;
        logic [3:0]        ax;
        logic [3:0]        ay;
        logic [8:0]        sqx;
        logic [8:0]        sqy;
        dx  = $signed({1'b0, cx}) - $signed({1'b0, qx});
        dy  = $signed({1'b0, cy}) - $signed({1'b0, qy});
        ax  = dx[4] ? 4'(-dx) : dx[3:0];
        ay  = dy[4] ? 4'(-dy) : dy[3:0];
        sqx = {5'd0, ax} * {5'd0, ax};
        sqy = {5'd0, ay} * {5'd0, ay};
        return (sqx + sqy) <= RADIUS_SQ;
    endfunction

    assign cand_x = cand_q[3:0];
    assign cand_y = cand_q[7:4];

    // The center that is not being scanned stays fixed for the whole scan.
    assign fix_x = phase_q ? w1x_q : w2x_q;
    assign fix_y = phase_q ? w1y_q : w2y_q;

    // Coverage of every stored point by the candidate and by the fixed center
    always_comb begin
        hit_cand = '0;
        hit_fix  = '0;
        for (int i = 0; i < NUM_PTS; i++) begin
            hit_cand[i] = covers(cand_x, cand_y, px_q[i], py_q[i]);
            hit_fix[i]  = covers(fix_x, fix_y, px_q[i], py_q[i]);
        end
    end

    // Union count: points covered by either center
    always_comb begin
        cand_cnt = '0;
        for (int i = 0; i < NUM_PTS; i++) begin
            if (hit_cand[i] || hit_fix[i]) begin
                cand_cnt = cand_cnt + 6'd1;
            end
        end
    end

    // Strictly-greater replacement keeps the first maximum in raster order
    always_comb begin
        take_cand = !best_vld_q || (cand_cnt > best_cnt_q);
        win_cnt   = take_cand ? cand_cnt : best_cnt_q;
        win_x     = take_cand ? cand_x   : best_x_q;
        win_y     = take_cand ? cand_y   : best_y_q;
    end

    assign scan_last = (cand_q == 8'hFF);

    // The search ends at the close of a circle-2 scan when the round did not
    // beat the previous round, or when the eighth round has just finished.
    assign search_end = (state_q == S_SEARCH) && scan_last && phase_q &&
                        ((round_q == LAST_ROUND) || (win_cnt <= prev_cnt_q));

    // FSM state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_READ;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_READ:   if (cnt_q == LAST_PT) state_d = S_SEARCH;
            S_SEARCH: if (search_end)       state_d = S_DONE;
            S_DONE:   state_d = S_READ;
            default:  state_d = S_READ;
        endcase
    end

    // FSM outputs: DONE is high only in the single presentation cycle
    always_comb begin
        DONE = 1'b0;
        if (state_q == S_DONE) begin
            DONE = 1'b1;
        end
    end

    // Point capture: one point per edge while in READ; the counter is parked
    // at zero elsewhere so the first READ edge always writes entry 0.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
            for (int i = 0; i < NUM_PTS; i++) begin
                px_q[i] <= '0;
                py_q[i] <= '0;
            end
        end else if (state_q == S_READ) begin
            px_q[cnt_q] <= X;
            py_q[cnt_q] <= Y;
            cnt_q       <= (cnt_q == LAST_PT) ? 6'd0 : cnt_q + 6'd1;
        end else begin
            cnt_q <= '0;
        end
    end

    // Search datapath: one raster candidate per cycle; registers are held at
    // their starting values (both centers at the origin) outside SEARCH.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            phase_q    <= 1'b0;
            cand_q     <= '0;
            best_vld_q <= 1'b0;
            best_cnt_q <= '0;
            best_x_q   <= '0;
            best_y_q   <= '0;
            w1x_q      <= '0;
            w1y_q      <= '0;
            w2x_q      <= '0;
            w2y_q      <= '0;
            round_q    <= '0;
            prev_cnt_q <= '0;
        end else if (state_q != S_SEARCH) begin
            phase_q    <= 1'b0;
            cand_q     <= '0;
            best_vld_q <= 1'b0;
            best_cnt_q <= '0;
            best_x_q   <= '0;
            best_y_q   <= '0;
            w1x_q      <= '0;
            w1y_q      <= '0;
            w2x_q      <= '0;
            w2y_q      <= '0;
            round_q    <= '0;
            prev_cnt_q <= '0;
        end else begin
            cand_q <= cand_q + 8'd1;
            if (scan_last) begin
                // Scan complete: the best candidate becomes the new center
                best_vld_q <= 1'b0;
                best_cnt_q <= '0;
                best_x_q   <= '0;
                best_y_q   <= '0;
                if (!phase_q) begin
                    w1x_q   <= win_x;
                    w1y_q   <= win_y;
                    phase_q <= 1'b1;
                end else begin
                    w2x_q      <= win_x;
                    w2y_q      <= win_y;
                    phase_q    <= 1'b0;
                    round_q    <= round_q + 3'd1;
                    prev_cnt_q <= win_cnt;
                end
            end else if (take_cand) begin
                best_vld_q <= 1'b1;
                best_cnt_q <= cand_cnt;
                best_x_q   <= cand_x;
                best_y_q   <= cand_y;
            end
        end
    end

    // Result registers: loaded once at search end, otherwise held
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            c1x_q <= '0;
            c1y_q <= '0;
            c2x_q <= '0;
            c2y_q <= '0;
        end else if (search_end) begin
            c1x_q <= w1x_q;
            c1y_q <= w1y_q;
            c2x_q <= win_x;
            c2y_q <= win_y;
        end
    end

    assign C1X = c1x_q;
    assign C1Y = c1y_q;
    assign C2X = c2x_q;
    assign C2Y = c2y_q;

endmodule

// File: tb/tb_laser_top.sv
// Testbench for laser_top: directed point sets, a reset abort during the
// search, back-to-back sets without reset and randomized point sets, all
// checked against a behavioural model of the alternating grid search.

`timescale 1ns/1ps

module tb_laser_top;

  localparam int NUM_PTS       = 40;
  localparam int DONE_LIMIT    = 50000;
  localparam int NUM_RAND_SETS = 24;

  logic       CLK;
  logic       RST;
  logic [3:0] X;
  logic [3:0] Y;
  logic [3:0] C1X;
  logic [3:0] C1Y;
  logic [3:0] C2X;
  logic [3:0] C2Y;
  logic       DONE;

  int n_cmp;
  int n_bad;

  int set_x [NUM_PTS];
  int set_y [NUM_PTS];

  // Result the outputs must currently hold
  logic [15:0] held_res;

  laser_top dut (
    .CLK  (CLK),
    .RST  (RST),
    .X    (X),
    .Y    (Y),
    .C1X  (C1X),
    .C1Y  (C1Y),
    .C2X  (C2X),
    .C2Y  (C2Y),
    .DONE (DONE)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit in_circle(int cx, int cy, int qx, int qy);
    return ((cx - qx) * (cx - qx) + (cy - qy) * (cy - qy)) <= 16;
  endfunction

  function automatic int union_cnt(int ax, int ay, int bx, int by);
    int n = 0;
    for (int i = 0; i < NUM_PTS; i++) begin
      if (in_circle(ax, ay, set_x[i], set_y[i]) || in_circle(bx, by, set_x[i], set_y[i]))
        n++;
    end
    return n;
  endfunction

  // Alternating coordinate search over the grid; returns final centers and
  // the number of rounds performed.
  task automatic ref_model(output int r1x, output int r1y, output int r2x,
                           output int r2y, output int rounds);
    int c1x = 0, c1y = 0, c2x = 0, c2y = 0;
    int prev = 0;
    int best, bx, by, n;
    rounds = 0;
    for (int r = 1; r <= 8; r++) begin
      best = -1; bx = 0; by = 0;
      for (int k = 0; k < 256; k++) begin
        n = union_cnt(k % 16, k / 16, c2x, c2y);
        if (n > best) begin best = n; bx = k % 16; by = k / 16; end
      end
      c1x = bx; c1y = by;
      best = -1; bx = 0; by = 0;
      for (int k = 0; k < 256; k++) begin
        n = union_cnt(k % 16, k / 16, c1x, c1y);
        if (n > best) begin best = n; bx = k % 16; by = k / 16; end
      end
      c2x = bx; c2y = by;
      rounds = r;
      if (best <= prev) break;
      prev = best;
    end
    r1x = c1x; r1y = c1y; r2x = c2x; r2y = c2y;
  endtask

  // ---------------- driver tasks ----------------
  // Holds reset low for a number of cycles, checking outputs stay cleared.
  task automatic apply_reset(input int cycles);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check_val("rst_done", DONE, 0);
    check_val("rst_centers", {C1X, C1Y, C2X, C2Y}, 0);
    for (int c = 0; c < cycles; c++) begin
      @(negedge CLK);
      check_val("rst_hold_done", DONE, 0);
      check_val("rst_hold_centers", {C1X, C1Y, C2X, C2Y}, 0);
    end
    RST = 1'b1;
    held_res = '0;
  endtask

  // Presents the 40 points, one per rising edge; starts at a negedge whose
  // following posedge is a capture edge.
  task automatic load_points();
    for (int i = 0; i < NUM_PTS; i++) begin
      X = 4'(set_x[i]);
      Y = 4'(set_y[i]);
      @(posedge CLK);
      @(negedge CLK);
      check_val("done_low_in_read", DONE, 0);
    end
  endtask

  // Loads the current set, waits for DONE and checks the result, the exact
  // latency, the single-cycle pulse and that outputs hold meanwhile.
  task automatic run_set(input string name);
    int e1x, e1y, e2x, e2y, rounds;
    int n;
    logic [15:0] exp_res;
    ref_model(e1x, e1y, e2x, e2y, rounds);
    exp_res = {4'(e1x), 4'(e1y), 4'(e2x), 4'(e2y)};
    load_points();
    n = 1;
    while (DONE !== 1'b1 && n < DONE_LIMIT) begin
      @(negedge CLK);
      n++;
      if (n == 300)
        check_val("hold_in_search", {C1X, C1Y, C2X, C2Y}, 32'(held_res));
    end
    if (DONE !== 1'b1) begin
      check_val({name, "_done_timeout"}, 0, 1);
      apply_reset(2);
      return;
    end
    check_val({name, "_latency"}, n, 512 * rounds + 1);
    check_val({name, "_result"}, {C1X, C1Y, C2X, C2Y}, 32'(exp_res));
    @(negedge CLK);
    check_val({name, "_done_pulse"}, DONE, 0);
    check_val({name, "_result_hold"}, {C1X, C1Y, C2X, C2Y}, 32'(exp_res));
    held_res = exp_res;
  endtask

  // Random point set: uniform, one cluster, or two clusters
  task automatic make_random_set();
    int mode, ax, ay, bx, by, v;
    mode = $urandom_range(0, 2);
    ax = $urandom_range(0, 15); ay = $urandom_range(0, 15);
    bx = $urandom_range(0, 15); by = $urandom_range(0, 15);
    for (int i = 0; i < NUM_PTS; i++) begin
      if (mode == 0) begin
        set_x[i] = $urandom_range(0, 15);
        set_y[i] = $urandom_range(0, 15);
      end else begin
        if (mode == 2 && i % 2 == 1) begin
          v = bx + $urandom_range(0, 6) - 3; set_x[i] = v < 0 ? 0 : (v > 15 ? 15 : v);
          v = by + $urandom_range(0, 6) - 3; set_y[i] = v < 0 ? 0 : (v > 15 ? 15 : v);
        end else begin
          v = ax + $urandom_range(0, 6) - 3; set_x[i] = v < 0 ? 0 : (v > 15 ? 15 : v);
          v = ay + $urandom_range(0, 6) - 3; set_y[i] = v < 0 ? 0 : (v > 15 ? 15 : v);
        end
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int unsigned seed_v;
    n_cmp    = 0;
    n_bad    = 0;
    held_res = '0;
    RST      = 1'b1;
    X        = '0;
    Y        = '0;
    seed_v   = $urandom(32'd2024);

    // Reset held low for three cycles
    #3;
    apply_reset(3);

    // All points on one spot
    for (int i = 0; i < NUM_PTS; i++) begin set_x[i] = 5; set_y[i] = 5; end
    run_set("same55");
    check_val("same55_spec", {C1X, C1Y, C2X, C2Y}, 32'h5100);

    // Two opposite corners, straight after the previous set
    for (int i = 0; i < NUM_PTS; i++) begin
      set_x[i] = (i < 20) ? 0 : 15;
      set_y[i] = (i < 20) ? 0 : 15;
    end
    run_set("corners2");
    check_val("corners2_spec", {C1X, C1Y, C2X, C2Y}, 32'hFB00);

    // Reset pulse in the middle of a search aborts immediately
    for (int i = 0; i < NUM_PTS; i++) begin
      set_x[i] = $urandom_range(0, 15);
      set_y[i] = $urandom_range(0, 15);
    end
    load_points();
    repeat (600) @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check_val("abort_done", DONE, 0);
    check_val("abort_centers", {C1X, C1Y, C2X, C2Y}, 0);
    held_res = '0;
    @(negedge CLK);
    check_val("abort_hold_centers", {C1X, C1Y, C2X, C2Y}, 0);
    RST = 1'b1;

    // Fresh load after the abort: four corner clusters
    for (int i = 0; i < NUM_PTS; i++) begin
      set_x[i] = (i % 4 == 1 || i % 4 == 3) ? 15 : 0;
      set_y[i] = (i % 4 >= 2) ? 15 : 0;
    end
    run_set("corners4");

    // Randomized sets, back to back without reset
    for (int s = 0; s < NUM_RAND_SETS; s++) begin
      make_random_set();
      run_set($sformatf("rand%0d", s));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
